// File: rtl/serial_adder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_adder_pkg : shared state encoding and WIDTH limits                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package serial_adder_pkg;

    localparam int unsigned c_WIDTH_MIN = 2;
    localparam int unsigned c_WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_adder_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_adder_ctrl_if : operand-in and result-out valid/ready handshakes    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface serial_adder_ctrl_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_c;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;

    modport master (
        output in_valid, in_a, in_b, in_c, out_ready,
        input  in_ready, out_valid, out_sum, out_carry
    );

    modport slave (
        input  in_valid, in_a, in_b, in_c, out_ready,
        output in_ready, out_valid, out_sum, out_carry
    );
endinterface
`default_nettype wire

// File: rtl/serial_fa_bit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_fa_bit : 1-bit combinational full-adder cell                        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module serial_fa_bit (
    input  wire logic a_i,
    input  wire logic b_i,
    input  wire logic ci_i,
    output logic      s_o,
    output logic      co_o
);
    assign s_o  = a_i ^ b_i ^ ci_i;
    assign co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_adder_ctrl : bit-serial adder, one full-adder cell, LSB first       |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    serial_adder_ctrl_if.slave bus
);
    localparam int unsigned    CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    if ((WIDTH < c_WIDTH_MIN) || (WIDTH > c_WIDTH_MAX)) begin : g_width_check
        $error("serial_adder_ctrl: WIDTH out of range");
    end

    state_t           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] sum_sr_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             sum_bit_d;
    logic             carry_d;

    serial_fa_bit u_fa (
        .a_i  (a_sr_q[0]),
        .b_i  (b_sr_q[0]),
        .ci_i (carry_q),
        .s_o  (sum_bit_d),
        .co_o (carry_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            sum_sr_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr_q     <= bus.in_a;
                        b_sr_q     <= bus.in_b;
                        carry_q    <= bus.in_c;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sum_sr_q <= {sum_bit_d, sum_sr_q[WIDTH-1:1]};
                    a_sr_q   <= a_sr_q >> 1;
                    b_sr_q   <= b_sr_q >> 1;
                    carry_q  <= carry_d;
                    // Counter holds at its last value so power-of-two widths never wrap.
                    if (cnt_q == CNT_LAST) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = sum_sr_q;
    assign bus.out_carry = carry_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_serial_adder_ctrl : directed self-checking bench, WIDTH=8 and WIDTH=5   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_serial_adder_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   cyc;

    serial_adder_ctrl_if #(.WIDTH(8)) bus8 ();
    serial_adder_ctrl_if #(.WIDTH(5)) bus5 ();

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    serial_adder_ctrl #(.WIDTH(5)) dut5 (
        .clk (clk),
        .rst (rst),
        .bus (bus5.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready8(input string tag);
        int n;
        n = 0;
        while (!bus8.in_ready && n < 40) begin
            tick();
            n++;
        end
        check_val({tag, "_ready"}, 32'(bus8.in_ready), 32'd1);
    endtask

    // Accept one bundle, scramble the inputs, measure latency, check the result.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic c, input logic [7:0] exp_sum, input logic exp_carry);
        int lat;
        wait_ready8(tag);
        bus8.in_a     = a;
        bus8.in_b     = b;
        bus8.in_c     = c;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        bus8.in_a     = ~a;
        bus8.in_b     = 8'h77;
        bus8.in_c     = ~c;
        lat = 0;
        while (!bus8.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_val({tag, "_lat"},   32'(lat),            32'd8);
        check_val({tag, "_sum"},   32'(bus8.out_sum),   32'(exp_sum));
        check_val({tag, "_carry"}, 32'(bus8.out_carry), 32'(exp_carry));
    endtask

    initial begin
        int           lat;
        int           seen;
        int           acc [3];
        logic [7:0]   va  [3];
        logic [7:0]   vb  [3];
        logic         vc  [3];
        logic [7:0]   es  [3];
        logic         ec  [3];

        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        bus8.in_valid = 1'b1; bus8.in_a = 8'hAA; bus8.in_b = 8'h55; bus8.in_c = 1'b1;
        bus8.out_ready = 1'b1;
        bus5.in_valid = 1'b0; bus5.in_a = '0; bus5.in_b = '0; bus5.in_c = 1'b0;
        bus5.out_ready = 1'b1;
        tick(); tick(); tick();

        check_val("rst_in_ready",  32'(bus8.in_ready),  32'd1);
        check_val("rst_out_valid", 32'(bus8.out_valid), 32'd0);
        check_val("rst_out_sum",   32'(bus8.out_sum),   32'd0);
        check_val("rst_out_carry", 32'(bus8.out_carry), 32'd0);
        bus8.in_valid = 1'b0;
        rst = 1'b0;
        tick();

        op8("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        tick();
        check_val("idle_after_done", 32'(bus8.in_ready), 32'd1);
        op8("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        tick();
        op8("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        tick();

        // Backpressure: result must hold while out_ready is low.
        bus8.out_ready = 1'b0;
        op8("bp", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("bp_valid",    32'(bus8.out_valid), 32'd1);
            check_val("bp_sum",      32'(bus8.out_sum),   32'h96);
            check_val("bp_carry",    32'(bus8.out_carry), 32'd0);
            check_val("bp_in_ready", 32'(bus8.in_ready),  32'd0);
        end
        bus8.out_ready = 1'b1;
        tick();
        check_val("bp_release_ready", 32'(bus8.in_ready), 32'd1);

        // Reset pulse during SHIFT aborts the operation.
        wait_ready8("abort");
        bus8.in_a = 8'h33; bus8.in_b = 8'h44; bus8.in_c = 1'b0;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus8.out_valid) seen = 1;
            tick();
        end
        check_val("abort_no_valid", 32'(seen), 32'd0);
        op8("after_abort", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);
        tick();

        // Back-to-back with in_valid held high.
        va = '{8'h12, 8'h80, 8'hA5};
        vb = '{8'h34, 8'h80, 8'h5A};
        vc = '{1'b0,  1'b1,  1'b1};
        es = '{8'h46, 8'h01, 8'h00};
        ec = '{1'b0,  1'b1,  1'b1};
        bus8.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus8.in_a = va[k]; bus8.in_b = vb[k]; bus8.in_c = vc[k];
            wait_ready8("b2b");
            tick();
            acc[k] = cyc;
            lat = 0;
            while (!bus8.out_valid && lat < 20) begin
                tick();
                lat++;
            end
            check_val("b2b_sum",   32'(bus8.out_sum),   32'(es[k]));
            check_val("b2b_carry", 32'(bus8.out_carry), 32'(ec[k]));
        end
        bus8.in_valid = 1'b0;
        check_val("b2b_gap01", 32'(acc[1] - acc[0]), 32'd10);
        check_val("b2b_gap12", 32'(acc[2] - acc[1]), 32'd10);
        tick();

        // WIDTH=5 instance.
        bus5.in_a = 5'h1F; bus5.in_b = 5'h01; bus5.in_c = 1'b1;
        bus5.in_valid = 1'b1;
        tick();
        bus5.in_valid = 1'b0;
        bus5.in_a = 5'h00;
        lat = 0;
        while (!bus5.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check_val("w5_lat",   32'(lat),            32'd5);
        check_val("w5_sum",   32'(bus5.out_sum),   32'h01);
        check_val("w5_carry", 32'(bus5.out_carry), 32'd1);
        tick();
        check_val("w5_idle", 32'(bus5.in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
